// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic [1:0] MC_IDLE   = 2'd0;
  localparam logic [1:0] MC_IF_RD  = 2'd1;
  localparam logic [1:0] MC_MEM_RD = 2'd2;
  localparam logic [1:0] MC_MEM_WR = 2'd3;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  // Index of the final byte of an access; the reserved length 11 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 2'd0;
      LEN_HALF: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] zext_load(input logic [31:0] w, input logic [1:0] last);
    case (last)
      2'd0:    return {24'h00_0000, w[7:0]};
      2'd1:    return {16'h0000, w[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and MEM-stage requests onto one 8-bit RAM port and
// sequences 1/2/4-byte little-endian accesses.
//   state     | meaning
//   MC_IDLE   | no access in progress
//   MC_IF_RD  | 4-byte instruction fetch
//   MC_MEM_RD | N-byte load
//   MC_MEM_WR | N-byte store
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [1:0]        cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       shadow_cap;

  always_comb begin
    cnt_nxt  = cnt_q + 2'd1;
    addr_nxt = addr_q + ADDR_W'(cnt_nxt);
    shadow_cap = shadow_q;
    shadow_cap[{cnt_q, 3'b000} +: 8] = ram_din;

    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shadow_d    = shadow_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    wr_d        = wr_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;

    // A pause freezes every register; the current byte is simply reissued.
    if (rdy_in) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        MC_IDLE: begin
          if (mem_req) begin
            addr_d     = mem_addr;
            wdata_d    = mem_wdata;
            last_d     = last_idx(mem_len);
            cnt_d      = 2'd0;
            ram_a_d    = mem_addr;
            ram_dout_d = mem_wdata[7:0];
            wr_d       = mem_we;
            state_d    = mem_we ? MC_MEM_WR : MC_MEM_RD;
          end else if (if_req && !if_flush) begin
            addr_d  = if_addr;
            last_d  = 2'd3;
            cnt_d   = 2'd0;
            ram_a_d = if_addr;
            wr_d    = 1'b0;
            state_d = MC_IF_RD;
          end
        end
        MC_IF_RD, MC_MEM_RD: begin
          if (state_q == MC_IF_RD && if_flush) begin
            state_d = MC_IDLE;
            cnt_d   = 2'd0;
          end else begin
            shadow_d = shadow_cap;
            if (cnt_q == last_q) begin
              if (state_q == MC_IF_RD) begin
                if_inst_d = shadow_cap;
                if_done_d = 1'b1;
              end else begin
                mem_rdata_d = zext_load(shadow_cap, last_q);
                mem_done_d  = 1'b1;
              end
              state_d = MC_IDLE;
              cnt_d   = 2'd0;
            end else begin
              cnt_d   = cnt_nxt;
              ram_a_d = addr_nxt;
            end
          end
        end
        default: begin
          if (cnt_q == last_q) begin
            wr_d       = 1'b0;
            mem_done_d = 1'b1;
            state_d    = MC_IDLE;
            cnt_d      = 2'd0;
          end else begin
            cnt_d      = cnt_nxt;
            ram_a_d    = addr_nxt;
            ram_dout_d = wdata_q[{cnt_nxt, 3'b000} +: 8];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= MC_IDLE;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= ZERO32;
      shadow_q    <= ZERO32;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZERO32;
      mem_rdata_q <= ZERO32;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shadow_q    <= shadow_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Strobes are masked while paused so a held register never looks like a second pulse.
  assign ram_wr    = wr_q & rdy_in;
  assign if_done   = if_done_q & rdy_in;
  assign mem_done  = mem_done_q & rdy_in;
  assign busy      = (state_q != MC_IDLE) | if_done_q | mem_done_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a combinational-read byte RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, busy, ram_wr;
  logic [31:0] if_inst, mem_rdata, ram_a;
  logic [7:0]  ram_din, ram_dout;

  logic [7:0] ram [0:4095];
  int n_chk = 0;
  int n_pass = 0;
  int nwr = 0;
  int nwr_base;

  always #5 clk_in = ~clk_in;

  assign ram_din = ram[ram_a[11:0]];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one clock; the RAM write strobe seen at the edge commits a byte.
  task automatic step();
    logic w;
    logic [11:0] a;
    logic [7:0] d;
    w = ram_wr;
    a = ram_a[11:0];
    d = ram_dout;
    @(posedge clk_in);
    if (w) begin
      ram[a] = d;
      nwr++;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]} = {8'h13, 8'h05, 8'hA0, 8'h00};
    {ram[12'h200], ram[12'h201], ram[12'h202], ram[12'h203]} = {8'h11, 8'h22, 8'h33, 8'h44};
    {ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h303]} = {8'hB7, 8'hC6, 8'hD5, 8'hE4};
    {ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001]} = {8'h01, 8'h02, 8'h03, 8'h04};

    rst_in = 1'b1; rdy_in = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;
    step(); step();
    chk("rst_flags", {28'h0, if_done, mem_done, busy, ram_wr}, 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_dout", {24'h0, ram_dout}, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    rst_in = 1'b0;
    step();

    // fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("fetch_a", ram_a, 32'h100 + k);
      chk("fetch_nodone", {31'h0, if_done}, 32'h0);
      step();
    end
    chk("fetch_done", {31'h0, if_done}, 32'h1);
    chk("fetch_inst", if_inst, 32'h00A00513);
    chk("fetch_busy", {31'h0, busy}, 32'h1);
    if_req = 1'b0;
    step();
    chk("fetch_idle", {30'h0, if_done, busy}, 32'h0);

    // half store at 0x20
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b01; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
    step();
    chk("sth_b0", {ram_wr, ram_a[22:0], ram_dout}, {1'b1, 23'h20, 8'hEF});
    step();
    chk("sth_b1", {ram_wr, ram_a[22:0], ram_dout}, {1'b1, 23'h21, 8'hBE});
    step();
    chk("sth_done", {29'h0, ram_wr, mem_done, busy}, 32'h3);
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    chk("sth_idle", {30'h0, mem_done, busy}, 32'h0);
    chk("sth_ram", {16'h0, ram[12'h21], ram[12'h20]}, 32'hBEEF);

    // simultaneous requests: load byte wins
    mem_req = 1'b1; mem_len = 2'b00; mem_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("prio_a", ram_a, 32'h20);
    step();
    chk("prio_mdone", {30'h0, mem_done, if_done}, 32'h2);
    chk("prio_rdata", mem_rdata, 32'h000000EF);
    mem_req = 1'b0;
    step();
    chk("prio_if_a", ram_a, 32'h100);
    step(); step(); step();
    chk("prio_if_nodone", {31'h0, if_done}, 32'h0);
    step();
    chk("prio_if_done", {31'h0, if_done}, 32'h1);
    chk("prio_if_inst", if_inst, 32'h00A00513);
    if_req = 1'b0;
    step();

    // flush during the second byte of a fetch at 0x200
    if_req = 1'b1; if_addr = 32'h200;
    step();
    step();
    chk("flush_a", ram_a, 32'h201);
    if_flush = 1'b1; if_addr = 32'h300;
    step();
    chk("flush_idle", {30'h0, if_done, busy}, 32'h0);
    chk("flush_inst", if_inst, 32'h00A00513);
    if_flush = 1'b0;
    step();
    chk("refetch_a", ram_a, 32'h300);
    step(); step(); step(); step();
    chk("refetch_done", {31'h0, if_done}, 32'h1);
    chk("refetch_inst", if_inst, 32'hE4D5C6B7);
    if_req = 1'b0;
    step();

    // word load wrapping past all-ones
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'hFFFFFFFE;
    step();
    chk("wrap_a0", ram_a, 32'hFFFFFFFE);
    step();
    chk("wrap_a1", ram_a, 32'hFFFFFFFF);
    step();
    chk("wrap_a2", ram_a, 32'h0);
    step();
    chk("wrap_a3", ram_a, 32'h1);
    step();
    chk("wrap_done", {31'h0, mem_done}, 32'h1);
    chk("wrap_rdata", mem_rdata, 32'h04030201);
    mem_req = 1'b0;
    step();

    // word store to 0x40 with a 3-cycle pause after the second byte is presented
    nwr_base = nwr;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h40; mem_wdata = 32'h87654321;
    step();
    chk("pst_b0", {ram_wr, ram_a[22:0], ram_dout}, {1'b1, 23'h40, 8'h21});
    step();
    rdy_in = 1'b0;
    #1;
    chk("pst_gate", {31'h0, ram_wr}, 32'h0);
    for (int p = 0; p < 3; p++) begin
      step();
      chk("pst_hold", {ram_wr, mem_done, busy, ram_a[20:0], ram_dout}, {3'b001, 21'h41, 8'h43});
    end
    rdy_in = 1'b1;
    #1;
    chk("pst_b1", {ram_wr, ram_a[22:0], ram_dout}, {1'b1, 23'h41, 8'h43});
    step();
    chk("pst_b2", {ram_wr, ram_a[22:0], ram_dout}, {1'b1, 23'h42, 8'h65});
    step();
    chk("pst_b3", {ram_wr, ram_a[22:0], ram_dout}, {1'b1, 23'h43, 8'h87});
    step();
    chk("pst_done", {30'h0, ram_wr, mem_done}, 32'h1);
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    chk("pst_nwr", nwr - nwr_base, 32'd4);
    chk("pst_ram", {ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]}, 32'h87654321);

    // reset during the third byte of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h80; mem_wdata = 32'hCAFEF00D;
    step(); step(); step();
    chk("rst3_a", ram_a, 32'h82);
    rst_in = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    step();
    chk("rst3_flags", {28'h0, if_done, mem_done, busy, ram_wr}, 32'h0);
    chk("rst3_bus", {ram_a[23:0], ram_dout}, 32'h0);
    chk("rst3_data", if_inst | mem_rdata, 32'h0);
    rst_in = 1'b0;
    step();
    chk("rst3_nodone", {30'h0, mem_done, busy}, 32'h0);
    mem_req = 1'b1; mem_len = 2'b01; mem_addr = 32'h80;
    step();
    chk("rst3_ld_a", ram_a, 32'h80);
    step(); step();
    chk("rst3_ld_done", {31'h0, mem_done}, 32'h1);
    chk("rst3_ld_rdata", mem_rdata, 32'h0000F00D);
    mem_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
